// File: rtl/lsu_mem_ctrl_if.sv
// Request/response bus between the CPU datapath and the LSU, and the LSU's
// word-wide data-memory bus.
interface lsu_req_if #(parameter int ADDR_W = 10);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface lsu_dm_if #(parameter int ADDR_W = 10);
  logic              dm_Wr;
  logic [1:0]        dm_mode;
  logic              dm_sign;
  logic [ADDR_W-3:0] dm_adr;
  logic [31:0]       dm_wd;
  logic [31:0]       dm_rd;

  modport master (output dm_Wr, dm_mode, dm_sign, dm_adr, dm_wd, input dm_rd);
  modport slave  (input dm_Wr, dm_mode, dm_sign, dm_adr, dm_wd, output dm_rd);
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator: byte-addressed requests in, word-only memory accesses out.
// Sub-word stores are read-modify-write; lane select and extension are done here.
module lsu_mem_ctrl #(
  parameter int ADDR_W          = 10,
  parameter bit ERR_ON_MISALIGN = 1'b1
) (
  input  logic      clk,
  input  logic      reset,
  lsu_req_if.slave  req,
  lsu_dm_if.master  dm
);

  typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_MERGE, S_ERR, S_RESP} state_t;

  state_t            r_state, w_next;
  logic              r_we, r_uns;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata, r_rdata, r_dm_wd;
  logic [ADDR_W-3:0] r_dm_adr;

  logic              w_ready, w_accept, w_misalign, w_err, w_word_store;
  logic [ADDR_W-1:0] w_addr_al;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_ldata, w_merged;

  assign w_ready      = (r_state == S_IDLE) && reset;
  assign w_accept     = req.req_valid && w_ready;
  assign w_word_store = r_we && r_size[1];
  assign w_err        = w_misalign && ERR_ON_MISALIGN;

  always_comb begin
    w_misalign = 1'b0;
    if (req.req_size[1])      w_misalign = |req.req_addr[1:0];
    else if (req.req_size[0]) w_misalign = req.req_addr[0];
  end

  // With errors disabled, misaligned requests fall back to the containing aligned unit.
  always_comb begin
    w_addr_al = req.req_addr;
    if (!ERR_ON_MISALIGN) begin
      if (req.req_size[1])      w_addr_al[1:0] = 2'b00;
      else if (req.req_size[0]) w_addr_al[0]   = 1'b0;
    end
  end

  // Lane extraction for loads and lane insertion for the RMW merge.
  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_byte = dm.dm_rd[7:0];
      2'd1:    w_byte = dm.dm_rd[15:8];
      2'd2:    w_byte = dm.dm_rd[23:16];
      default: w_byte = dm.dm_rd[31:24];
    endcase
    w_half = r_addr[1] ? dm.dm_rd[31:16] : dm.dm_rd[15:0];

    if (r_size[1])      w_ldata = dm.dm_rd;
    else if (r_size[0]) w_ldata = {{16{~r_uns & w_half[15]}}, w_half};
    else                w_ldata = {{24{~r_uns & w_byte[7]}}, w_byte};

    w_merged = dm.dm_rd;
    if (r_size[0]) begin
      if (r_addr[1]) w_merged[31:16] = r_wdata[15:0];
      else           w_merged[15:0]  = r_wdata[15:0];
    end else begin
      case (r_addr[1:0])
        2'd0:    w_merged[7:0]   = r_wdata[7:0];
        2'd1:    w_merged[15:8]  = r_wdata[7:0];
        2'd2:    w_merged[23:16] = r_wdata[7:0];
        default: w_merged[31:24] = r_wdata[7:0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = w_err ? S_ERR : S_ACCESS;
      S_ACCESS: w_next = (r_we && !r_size[1]) ? S_MERGE : S_RESP;
      S_MERGE:  w_next = S_RESP;
      S_ERR:    w_next = S_IDLE;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Write enable is decoded from state so an async reset kills it at once.
  always_comb begin
    req.req_ready  = w_ready;
    req.resp_valid = (r_state == S_RESP) || (r_state == S_ERR);
    req.resp_err   = (r_state == S_ERR);
    req.resp_rdata = r_rdata;
    dm.dm_Wr       = ((r_state == S_ACCESS) && w_word_store) || (r_state == S_MERGE);
    dm.dm_mode     = 2'b10;
    dm.dm_sign     = 1'b0;
    dm.dm_adr      = r_dm_adr;
    dm.dm_wd       = r_dm_wd;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we     <= 1'b0;
      r_uns    <= 1'b0;
      r_size   <= 2'b00;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_dm_wd  <= '0;
      r_dm_adr <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_we    <= req.req_we;
          r_uns   <= req.req_unsigned;
          r_size  <= req.req_size;
          r_addr  <= w_addr_al;
          r_wdata <= req.req_wdata;
          if (w_err) r_rdata <= '0;
          else begin
            r_dm_adr <= w_addr_al[ADDR_W-1:2];
            if (req.req_we && req.req_size[1]) r_dm_wd <= req.req_wdata;
          end
        end
        S_ACCESS: begin
          if (!r_we)          r_rdata <= w_ldata;
          else if (r_size[1]) r_rdata <= '0;
          else                r_dm_wd <= w_merged;
        end
        S_MERGE: r_rdata <= '0;
        default: ;
      endcase
    end
  end

endmodule
